// File: rtl/spart_pkg.sv
// Shared SPART definitions used by the packer and the receive queue.
package spart_pkg;

  localparam int unsigned SPART_MSG_W = 24;

  typedef logic [SPART_MSG_W-1:0] spart_msg_t;

endpackage

// File: rtl/spart_rxq_mem.sv
// Register-array storage for the receive queue.
// It has one synchronous write port and one asynchronous read port, so it can later be swapped for a RAM.
module spart_rxq_mem #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned MSG_W = 24,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [MSG_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [MSG_W-1:0] rdata
);

  logic [MSG_W-1:0] r_mem [DEPTH];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/spart_rx_queue.sv
// Show-ahead receive message FIFO downstream of the SPART packer, with a sticky overflow flag.
// The optional dropped-message counter is built when SPART_RXQ_DROP_CNT_EN is defined.
module spart_rx_queue
  import spart_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned MSG_W = SPART_MSG_W,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             msg_valid,
  input  logic [MSG_W-1:0] msg_data,
  input  logic             rd_en,
  output logic [MSG_W-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             irq,
  output logic             overflow,
  input  logic             clr_overflow,
  output logic [7:0]       drop_cnt
);

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [MSG_W-1:0] w_rdata;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  // A pop frees a slot in the same cycle, so a push while full and popping is not a drop.
  assign w_pop   = rd_en && !w_empty;
  assign w_push  = msg_valid && (!w_full || w_pop);
  assign w_drop  = msg_valid && w_full && !rd_en;

  spart_rxq_mem #(
    .DEPTH (DEPTH),
    .MSG_W (MSG_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_push),
    .waddr (r_wr_ptr),
    .wdata (msg_data),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
      // A new drop wins over a clear issued in the same cycle.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

`ifdef SPART_RXQ_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  // Saturating drop counter; a drop in the same cycle as a clear leaves the counter at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      if (clr_overflow) begin
        r_drop_cnt <= 8'd1;
      end else if (r_drop_cnt != 8'hFF) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end else if (clr_overflow) begin
      r_drop_cnt <= '0;
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = '0;
`endif

  assign rd_data  = w_empty ? '0 : w_rdata;
  assign empty    = w_empty;
  assign full     = w_full;
  assign irq      = !w_empty;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_spart_rx_queue.sv
// Scoreboard bench for spart_rx_queue: directed pushes and pops, with popped words checked by a monitor.
module tb_spart_rx_queue;

  logic        clk;
  logic        rst_n;
  logic        msg_valid;
  logic [23:0] msg_data;
  logic        rd_en;
  logic [23:0] rd_data;
  logic        empty;
  logic        full;
  logic [3:0]  count;
  logic        irq;
  logic        overflow;
  logic        clr_overflow;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [23:0] mq[$];
  logic [23:0] exp_q[$];
  logic        m_ovf = 1'b0;
  logic [7:0]  m_dc  = 8'd0;

  spart_rx_queue #(.DEPTH(8), .MSG_W(24)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .msg_valid    (msg_valid),
    .msg_data     (msg_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .irq          (irq),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .drop_cnt     (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: act=%0h req=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: each accepted pop must present the scoreboard's next word.
  always @(negedge clk) begin
    if (rst_n && rd_en && !empty) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL pop_unexpected: act=%0h req=none", rd_data);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          n_errors++;
          $display("FAIL pop_data: act=%0h req=%0h at %0t", rd_data, e, $time);
        end
      end
    end
  end

  // Drives one cycle of inputs and updates the reference queue model.
  task automatic step(input logic v, input logic [23:0] d, input logic r, input logic c);
    logic m_full, m_pop, m_push, m_drop;
    msg_valid = v; msg_data = d; rd_en = r; clr_overflow = c;
    m_full = (mq.size() == 8);
    m_pop  = r && (mq.size() != 0);
    m_push = v && (!m_full || m_pop);
    m_drop = v && m_full && !r;
    if (m_pop) exp_q.push_back(mq.pop_front());
    if (m_push) mq.push_back(d);
    if (m_drop) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
`ifdef SPART_RXQ_DROP_CNT_EN
    if (m_drop) m_dc = c ? 8'd1 : ((m_dc == 8'hFF) ? 8'hFF : m_dc + 8'd1);
    else if (c) m_dc = 8'd0;
`endif
    @(posedge clk);
    #1;
    msg_valid = 1'b0; rd_en = 1'b0; clr_overflow = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"},    32'(count),    32'(mq.size()));
    check({tag, ".empty"},    32'(empty),    32'(mq.size() == 0));
    check({tag, ".full"},     32'(full),     32'(mq.size() == 8));
    check({tag, ".irq"},      32'(irq),      32'(mq.size() != 0));
    check({tag, ".rd_data"},  32'(rd_data),  (mq.size() == 0) ? 32'd0 : 32'(mq[0]));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_dc));
  endtask

  initial begin
    rst_n = 1'b0; msg_valid = 1'b0; msg_data = '0; rd_en = 1'b0; clr_overflow = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.empty",   32'(empty),   32'd1);
    check("rst.full",    32'(full),    32'd0);
    check("rst.irq",     32'(irq),     32'd0);
    check("rst.count",   32'(count),   32'd0);
    check("rst.rd_data", 32'(rd_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // A single push becomes visible at the head on the next cycle.
    step(1'b1, 24'hA1B2C3, 1'b0, 1'b0);
    check("push1.rd_data", 32'(rd_data), 32'h00A1B2C3);
    check("push1.count",   32'(count),   32'd1);
    check_state("push1");
    step(1'b0, 24'h0, 1'b1, 1'b0);
    check("pop1.empty",   32'(empty),   32'd1);
    check("pop1.rd_data", 32'(rd_data), 32'd0);

    // A pop while the queue is empty must be ignored.
    step(1'b0, 24'h0, 1'b1, 1'b0);
    check_state("pop_empty");

    for (int i = 0; i < 8; i++) step(1'b1, 24'h100000 + 24'(i * 24'h111), 1'b0, 1'b0);
    check("fill.full",  32'(full),  32'd1);
    check("fill.count", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) step(1'b0, 24'h0, 1'b1, 1'b0);
    check_state("drain");

    // The second fill wraps both pointers.
    for (int i = 0; i < 8; i++) step(1'b1, 24'h200000 + 24'(i * 24'h0F0F), 1'b0, 1'b0);
    check_state("fill2");
    step(1'b1, 24'h123456, 1'b0, 1'b0);
    check("drop.overflow", 32'(overflow), 32'd1);
    check("drop.count",    32'(count),    32'd8);
    check("drop.head",     32'(rd_data),  32'h00200000);
    check_state("drop");

    step(1'b1, 24'h777777, 1'b1, 1'b0);
    check("pushpop_full.count", 32'(count), 32'd8);
    check_state("pushpop_full");
    for (int i = 0; i < 8; i++) step(1'b0, 24'h0, 1'b1, 1'b0);
    check_state("drain2");

    step(1'b1, 24'hABCDEF, 1'b1, 1'b0);
    check("pushpop_empty.count", 32'(count), 32'd1);
    check_state("pushpop_empty");

    for (int i = 0; i < 7; i++) step(1'b1, 24'h300000 + 24'(i), 1'b0, 1'b0);
    step(1'b1, 24'hDEAD01, 1'b0, 1'b0);
    check_state("drop2");
    step(1'b1, 24'hDEAD02, 1'b0, 1'b1);
    check("drop_clr.overflow", 32'(overflow), 32'd1);
    check_state("drop_clr");
    step(1'b0, 24'h0, 1'b0, 1'b1);
    check("clr.overflow", 32'(overflow), 32'd0);
    check("clr.drop_cnt", 32'(drop_cnt), 32'd0);
    check_state("clr");

    // Set overflow again, drain to 5, then reset asynchronously away from any clock edge.
    step(1'b1, 24'hDEAD03, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 24'h0, 1'b1, 1'b0);
    check_state("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete(); m_ovf = 1'b0; m_dc = 8'd0;
    check("arst.empty",    32'(empty),    32'd1);
    check("arst.irq",      32'(irq),      32'd0);
    check("arst.count",    32'(count),    32'd0);
    check("arst.overflow", 32'(overflow), 32'd0);
    check_state("arst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 24'h0BEEF0, 1'b0, 1'b0);
    check_state("post_rst");
    step(1'b0, 24'h0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    check("scoreboard.left", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
